// File: rtl/montgomery_mul_pipe.sv
// Three-stage pipelined Montgomery multiplier/reducer: out = P * 2^-W mod Q.
// Stages hold together on output backpressure; in_ready mirrors the advance enable.
module montgomery_mul_pipe #(
   parameter int W = 16,
   parameter logic [W-1:0] Q = W'(3329),
   parameter logic [W-1:0] QPRIME = W'(3327),
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic [2*W-1:0]   p;
   } s1_t;

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic [2*W-1:0]   p;
      logic [W-1:0]     m;
   } s2_t;

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic [W-1:0]     data;
   } s3_t;

   s1_t s1;
   s2_t s2;
   s3_t s3;

   logic           advance;
   logic [2*W-1:0] p_in;
   logic [W-1:0]   m_in;
   logic [2*W:0]   sum;
   logic [W:0]     t;
   logic [W-1:0]   r;
   logic           unused_lo;

   assign advance = ~s3.v | out_ready;
   assign in_ready = advance;

   assign p_in = in_mode ? {in_b, in_a}
                         : {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};

   assign m_in = s1.p[W-1:0] * QPRIME;

   // Low W bits of P + m*Q are zero by construction of m.
   assign sum = {1'b0, s2.p}
              + ({{(W+1){1'b0}}, s2.m} * {{(W+1){1'b0}}, Q});
   assign t = sum[2*W:W];
   assign unused_lo = ^sum[W-1:0];

   assign r = (t >= {1'b0, Q}) ? W'(t - {1'b0, Q}) : t[W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else if (advance) begin
         s1.v    <= in_valid;
         s1.tag  <= in_tag;
         s1.p    <= p_in;
         s2.v    <= s1.v;
         s2.tag  <= s1.tag;
         s2.p    <= s1.p;
         s2.m    <= m_in;
         s3.v    <= s2.v;
         s3.tag  <= s2.tag;
         s3.data <= r;
      end
   end

   assign out_valid = s3.v;
   assign out_data  = s3.data;
   assign out_tag   = s3.tag;
   assign busy      = s1.v | s2.v | s3.v;

endmodule
